// File: rtl/exec_stage_pkg.sv
// Shared definitions for the execute stage: opcodes, flag bit positions, FSM states and opcode decode.
// EXEC_MUL_EN selects whether IMUL (AF) decodes as a real operation or as illegal.
package exec_stage_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 32;

  localparam logic [7:0] OPC_ADD  = 8'h01;
  localparam logic [7:0] OPC_OR   = 8'h09;
  localparam logic [7:0] OPC_AND  = 8'h21;
  localparam logic [7:0] OPC_SUB  = 8'h29;
  localparam logic [7:0] OPC_XOR  = 8'h31;
  localparam logic [7:0] OPC_CMP  = 8'h39;
  localparam logic [7:0] OPC_MOV  = 8'h89;
  localparam logic [7:0] OPC_IMUL = 8'hAF;
  localparam logic [4:0] OPC_INC_HI = 5'b01000;
  localparam logic [4:0] OPC_DEC_HI = 5'b01001;

  localparam int FLAG_ZF = 0;
  localparam int FLAG_CF = 1;
  localparam int FLAG_SF = 2;
  localparam int FLAG_OF = 3;

`ifdef EXEC_MUL_EN
  localparam bit MUL_SUPPORTED = 1'b1;
`else
  localparam bit MUL_SUPPORTED = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } exec_state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_OR, OP_AND, OP_SUB, OP_XOR, OP_CMP,
    OP_MOV, OP_INC, OP_DEC, OP_IMUL, OP_ILLEGAL
  } op_e;

  function automatic op_e decode_op(input logic [7:0] opc);
    op_e op;
    op = OP_ILLEGAL;
    case (opc)
      OPC_ADD:  op = OP_ADD;
      OPC_OR:   op = OP_OR;
      OPC_AND:  op = OP_AND;
      OPC_SUB:  op = OP_SUB;
      OPC_XOR:  op = OP_XOR;
      OPC_CMP:  op = OP_CMP;
      OPC_MOV:  op = OP_MOV;
      OPC_IMUL: op = MUL_SUPPORTED ? OP_IMUL : OP_ILLEGAL;
      default: begin
        if (opc[7:3] == OPC_INC_HI)      op = OP_INC;
        else if (opc[7:3] == OPC_DEC_HI) op = OP_DEC;
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/exec_mult.sv
// Iterative signed multiplier: multiplies operand magnitudes by shift-add, one bit per cycle,
// then applies the sign to the full 2*DATA_W product. o_done marks the cycle of the final iteration.
module exec_mult
  import exec_stage_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_op_a,
  input  logic [DATA_W-1:0]     i_op_b,
  output logic                  o_done,
  output logic [2*DATA_W-1:0]   o_product
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic                r_busy;
  logic [CNT_W-1:0]    r_count;
  logic [2*DATA_W-1:0] r_acc;
  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic                r_neg;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;

  // The most negative operand's magnitude still fits in DATA_W unsigned bits.
  assign w_mag_a = i_op_a[DATA_W-1] ? -i_op_a : i_op_a;
  assign w_mag_b = i_op_b[DATA_W-1] ? -i_op_b : i_op_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy   <= 1'b0;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= {{DATA_W{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_neg    <= i_op_a[DATA_W-1] ^ i_op_b[DATA_W-1];
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CNT_W'(1);
      if (r_count == LAST) r_busy <= 1'b0;
    end
  end

  assign o_done    = r_busy && (r_count == LAST);
  assign o_product = r_neg ? -r_acc : r_acc;

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU with registered result bundle and architectural flags.
// Define EXEC_MUL_EN to add the iterative IMUL path (MUL/DONE states and exec_mult).
module exec_stage
  import exec_stage_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int ADDR_W = ADDRESS_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_input_valid,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [7:0]        i_opcode,
  input  logic [DATA_W-1:0] i_dst_val,
  input  logic [DATA_W-1:0] i_src_val,
  input  logic [3:0]        i_dst_reg,
  input  logic              i_dst_is_mem,
  input  logic [ADDR_W-1:0] i_dst_addr,
  input  logic              i_next_ready,
  output logic              o_ready,
  output logic              o_res_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_result,
  output logic [3:0]        o_dst_reg,
  output logic              o_dst_is_mem,
  output logic [ADDR_W-1:0] o_dst_addr,
  output logic              o_wr_en,
  output logic [3:0]        o_flags,
  output logic              o_illegal
);

  localparam int MSB = DATA_W - 1;
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_result;
  logic [3:0]        r_dst_reg;
  logic              r_dst_is_mem;
  logic [ADDR_W-1:0] r_dst_addr;
  logic              r_wr_en;
  logic [3:0]        r_flags;
  logic              r_illegal;

  op_e               w_op;
  logic              w_idle;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_alu_load;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_alu_result;
  logic [3:0]        w_alu_flags;
  logic              w_alu_wr_en;
  logic              w_alu_illegal;
  logic              w_set_zs;

  assign w_op        = decode_op(i_opcode);
  assign w_slot_free = !r_valid || i_next_ready;
  assign o_ready     = w_idle && w_slot_free;
  assign w_accept    = i_input_valid && o_ready;
  assign w_alu_load  = w_accept && (w_op != OP_IMUL);

  assign w_sum  = {1'b0, i_dst_val} + {1'b0, i_src_val};
  assign w_diff = {1'b0, i_dst_val} - {1'b0, i_src_val};

  // Flags start from the current architectural value so INC/DEC keep CF and MOV/illegal keep all.
  always_comb begin
    w_alu_result  = i_dst_val;
    w_alu_flags   = r_flags;
    w_alu_wr_en   = 1'b1;
    w_alu_illegal = 1'b0;
    w_set_zs      = 1'b1;
    case (w_op)
      OP_ADD: begin
        w_alu_result         = w_sum[MSB:0];
        w_alu_flags[FLAG_CF] = w_sum[DATA_W];
        w_alu_flags[FLAG_OF] = (i_dst_val[MSB] == i_src_val[MSB]) && (w_sum[MSB] != i_dst_val[MSB]);
      end
      OP_SUB, OP_CMP: begin
        w_alu_result         = w_diff[MSB:0];
        w_alu_flags[FLAG_CF] = w_diff[DATA_W];
        w_alu_flags[FLAG_OF] = (i_dst_val[MSB] != i_src_val[MSB]) && (w_diff[MSB] != i_dst_val[MSB]);
        w_alu_wr_en          = (w_op != OP_CMP);
      end
      OP_AND, OP_OR, OP_XOR: begin
        w_alu_result         = (w_op == OP_AND) ? (i_dst_val & i_src_val) :
                               (w_op == OP_OR)  ? (i_dst_val | i_src_val) :
                                                  (i_dst_val ^ i_src_val);
        w_alu_flags[FLAG_CF] = 1'b0;
        w_alu_flags[FLAG_OF] = 1'b0;
      end
      OP_INC: begin
        w_alu_result         = i_dst_val + DATA_W'(1);
        w_alu_flags[FLAG_OF] = (i_dst_val == MAX_POS);
      end
      OP_DEC: begin
        w_alu_result         = i_dst_val - DATA_W'(1);
        w_alu_flags[FLAG_OF] = (i_dst_val == MIN_NEG);
      end
      OP_MOV: begin
        w_alu_result = i_src_val;
        w_set_zs     = 1'b0;
      end
      default: begin
        w_alu_wr_en   = 1'b0;
        w_alu_illegal = 1'b1;
        w_set_zs      = 1'b0;
      end
    endcase
    if (w_set_zs) begin
      w_alu_flags[FLAG_ZF] = (w_alu_result == '0);
      w_alu_flags[FLAG_SF] = w_alu_result[MSB];
    end
  end

`ifdef EXEC_MUL_EN
  exec_state_e         r_state;
  exec_state_e         w_state_next;
  logic                w_mul_start;
  logic                w_mul_done;
  logic                w_mul_load;
  logic                w_mul_ovf;
  logic [2*DATA_W-1:0] w_product;
  logic [ADDR_W-1:0]   r_mul_pc;
  logic [3:0]          r_mul_dst_reg;
  logic                r_mul_dst_is_mem;
  logic [ADDR_W-1:0]   r_mul_dst_addr;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_mul_start = w_accept && (w_op == OP_IMUL);
  assign w_mul_load  = (r_state == ST_DONE) && w_slot_free;
  assign w_mul_ovf   = (w_product[2*DATA_W-1:DATA_W] != {DATA_W{w_product[MSB]}});

  exec_mult #(.DATA_W(DATA_W)) u_mult (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_mul_start),
    .i_op_a    (i_dst_val),
    .i_op_b    (i_src_val),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
      ST_MUL:  if (w_mul_done)  w_state_next = ST_DONE;
      ST_DONE: if (w_slot_free) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The destination descriptor must survive the multiply because the inputs move on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mul_pc         <= '0;
      r_mul_dst_reg    <= '0;
      r_mul_dst_is_mem <= 1'b0;
      r_mul_dst_addr   <= '0;
    end else if (w_mul_start) begin
      r_mul_pc         <= i_pc;
      r_mul_dst_reg    <= i_dst_reg;
      r_mul_dst_is_mem <= i_dst_is_mem;
      r_mul_dst_addr   <= i_dst_addr;
    end
  end
`else
  assign w_idle = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_result     <= '0;
      r_dst_reg    <= '0;
      r_dst_is_mem <= 1'b0;
      r_dst_addr   <= '0;
      r_wr_en      <= 1'b0;
      r_flags      <= '0;
      r_illegal    <= 1'b0;
    end else if (w_alu_load) begin
      r_valid      <= 1'b1;
      r_pc         <= i_pc;
      r_result     <= w_alu_result;
      r_dst_reg    <= i_dst_reg;
      r_dst_is_mem <= i_dst_is_mem;
      r_dst_addr   <= i_dst_addr;
      r_wr_en      <= w_alu_wr_en;
      r_flags      <= w_alu_flags;
      r_illegal    <= w_alu_illegal;
`ifdef EXEC_MUL_EN
    end else if (w_mul_load) begin
      r_valid          <= 1'b1;
      r_pc             <= r_mul_pc;
      r_result         <= w_product[MSB:0];
      r_dst_reg        <= r_mul_dst_reg;
      r_dst_is_mem     <= r_mul_dst_is_mem;
      r_dst_addr       <= r_mul_dst_addr;
      r_wr_en          <= 1'b1;
      r_flags[FLAG_CF] <= w_mul_ovf;
      r_flags[FLAG_OF] <= w_mul_ovf;
      r_illegal        <= 1'b0;
`endif
    end else if (i_next_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_res_valid  = r_valid;
  assign o_pc         = r_pc;
  assign o_result     = r_result;
  assign o_dst_reg    = r_dst_reg;
  assign o_dst_is_mem = r_dst_is_mem;
  assign o_dst_addr   = r_dst_addr;
  assign o_wr_en      = r_wr_en;
  assign o_flags      = r_flags;
  assign o_illegal    = r_illegal;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: cycle-level reference model plus directed and random stimulus.
// Honours EXEC_MUL_EN the same way as the design (AF is IMUL when defined, illegal otherwise).
module tb_exec_stage;

  logic        clk;
  logic        reset;
  logic        i_input_valid;
  logic [31:0] i_pc;
  logic [7:0]  i_opcode;
  logic [31:0] i_dst_val;
  logic [31:0] i_src_val;
  logic [3:0]  i_dst_reg;
  logic        i_dst_is_mem;
  logic [31:0] i_dst_addr;
  logic        i_next_ready;
  logic        o_ready;
  logic        o_res_valid;
  logic [31:0] o_pc;
  logic [31:0] o_result;
  logic [3:0]  o_dst_reg;
  logic        o_dst_is_mem;
  logic [31:0] o_dst_addr;
  logic        o_wr_en;
  logic [3:0]  o_flags;
  logic        o_illegal;

`ifdef EXEC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif
  localparam int MUL_LATENCY = 33;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: output slot, flags, and a countdown for an in-flight multiply.
  bit          mValid;
  logic [31:0] mPc, mResult, mAddr;
  logic [3:0]  mDstReg, mFlags;
  bit          mIsMem, mWrEn, mIllegal;
  int          mMulLeft;
  logic [31:0] pPc, pResult, pAddr;
  logic [3:0]  pDstReg;
  bit          pIsMem, pOvf;
  bit          mAccepted;

  exec_stage dut (
    .clk          (clk),
    .reset        (reset),
    .i_input_valid(i_input_valid),
    .i_pc         (i_pc),
    .i_opcode     (i_opcode),
    .i_dst_val    (i_dst_val),
    .i_src_val    (i_src_val),
    .i_dst_reg    (i_dst_reg),
    .i_dst_is_mem (i_dst_is_mem),
    .i_dst_addr   (i_dst_addr),
    .i_next_ready (i_next_ready),
    .o_ready      (o_ready),
    .o_res_valid  (o_res_valid),
    .o_pc         (o_pc),
    .o_result     (o_result),
    .o_dst_reg    (o_dst_reg),
    .o_dst_is_mem (o_dst_is_mem),
    .o_dst_addr   (o_dst_addr),
    .o_wr_en      (o_wr_en),
    .o_flags      (o_flags),
    .o_illegal    (o_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ovf32(input longint v);
    logic [31:0] lo;
    lo = v[31:0];
    return v != longint'($signed(lo));
  endfunction

  function automatic bit isImul(input logic [7:0] opc);
    return MUL_ON && (opc == 8'hAF);
  endfunction

  // Flags are {OF, SF, CF, ZF}; computed from signed/unsigned integer ranges.
  task automatic modelAlu(input logic [7:0] opc, input logic [31:0] d, input logic [31:0] s,
                          input logic [3:0] fin, output logic [31:0] r, output logic [3:0] f,
                          output bit we, output bit ill);
    longint sd, ss;
    bit zs;
    sd = longint'($signed(d));
    ss = longint'($signed(s));
    r = d; f = fin; we = 1'b1; ill = 1'b0; zs = 1'b1;
    if (opc == 8'h01) begin
      r = d + s; f[1] = (longint'(d) + longint'(s)) > 64'hFFFF_FFFF; f[3] = ovf32(sd + ss);
    end else if (opc == 8'h29 || opc == 8'h39) begin
      r = d - s; f[1] = d < s; f[3] = ovf32(sd - ss); we = (opc == 8'h29);
    end else if (opc == 8'h21) begin
      r = d & s; f[1] = 0; f[3] = 0;
    end else if (opc == 8'h09) begin
      r = d | s; f[1] = 0; f[3] = 0;
    end else if (opc == 8'h31) begin
      r = d ^ s; f[1] = 0; f[3] = 0;
    end else if (opc >= 8'h40 && opc <= 8'h47) begin
      r = d + 1; f[3] = ovf32(sd + 1);
    end else if (opc >= 8'h48 && opc <= 8'h4F) begin
      r = d - 1; f[3] = ovf32(sd - 1);
    end else if (opc == 8'h89) begin
      r = s; zs = 1'b0;
    end else begin
      we = 1'b0; ill = 1'b1; zs = 1'b0;
    end
    if (zs) begin
      f[0] = (r == 32'h0);
      f[2] = r[31];
    end
  endtask

  task automatic modelReset();
    mValid = 0; mPc = 0; mResult = 0; mAddr = 0; mDstReg = 0; mFlags = 0;
    mIsMem = 0; mWrEn = 0; mIllegal = 0; mMulLeft = 0; mAccepted = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic modelStep();
    bit slotFree, rdy;
    logic [31:0] r;
    logic [3:0] f;
    bit we, ill;
    longint prod;
    int leftNext;
    slotFree = !mValid || i_next_ready;
    rdy = (mMulLeft == 0) && slotFree;
    mAccepted = i_input_valid && rdy;
    leftNext = mMulLeft;
    if (mAccepted && isImul(i_opcode)) begin
      prod = longint'($signed(i_dst_val)) * longint'($signed(i_src_val));
      pResult = prod[31:0]; pOvf = ovf32(prod);
      pPc = i_pc; pDstReg = i_dst_reg; pIsMem = i_dst_is_mem; pAddr = i_dst_addr;
      leftNext = MUL_LATENCY;
    end else if (mMulLeft > 1) begin
      leftNext = mMulLeft - 1;
    end
    if (mAccepted && !isImul(i_opcode)) begin
      modelAlu(i_opcode, i_dst_val, i_src_val, mFlags, r, f, we, ill);
      mValid = 1; mPc = i_pc; mResult = r; mDstReg = i_dst_reg; mIsMem = i_dst_is_mem;
      mAddr = i_dst_addr; mWrEn = we; mIllegal = ill; mFlags = f;
    end else if (mMulLeft == 1 && slotFree) begin
      mValid = 1; mPc = pPc; mResult = pResult; mDstReg = pDstReg; mIsMem = pIsMem;
      mAddr = pAddr; mWrEn = 1; mIllegal = 0; mFlags[1] = pOvf; mFlags[3] = pOvf;
      leftNext = 0;
    end else if (i_next_ready) begin
      mValid = 0;
    end
    mMulLeft = leftNext;
  endtask

  task automatic checkOutput();
    check("res_valid", o_res_valid, mValid);
    check("ready", o_ready, (mMulLeft == 0) && (!mValid || i_next_ready));
    check("flags", o_flags, mFlags);
    if (mValid) begin
      check("pc", o_pc, mPc);
      check("result", o_result, mResult);
      check("dst_reg", o_dst_reg, mDstReg);
      check("dst_is_mem", o_dst_is_mem, mIsMem);
      check("dst_addr", o_dst_addr, mAddr);
      check("wr_en", o_wr_en, mWrEn);
      check("illegal", o_illegal, mIllegal);
    end
  endtask

  // Drive one cycle of inputs just after a falling edge, then compare at the next falling edge.
  task automatic applyStimulus(input bit v, input logic [7:0] opc, input logic [31:0] d,
                               input logic [31:0] s, input bit nr);
    i_input_valid = v;
    i_opcode      = opc;
    i_dst_val     = d;
    i_src_val     = s;
    i_next_ready  = nr;
    i_pc          = $urandom;
    i_dst_reg     = 4'($urandom_range(0, 15));
    i_dst_is_mem  = 1'($urandom_range(0, 1));
    i_dst_addr    = $urandom;
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic sendOp(input logic [7:0] opc, input logic [31:0] d, input logic [31:0] s);
    int tries;
    tries = 0;
    do begin
      applyStimulus(1, opc, d, s, 1);
      tries++;
    end while (!mAccepted && tries < 100);
    if (!mAccepted) check("accept_timeout", 1, 0);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 8'($urandom), $urandom, $urandom, 1);
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    while (!o_res_valid && cycles < 60) begin
      idleCycle();
      cycles++;
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    i_input_valid = 1'b0;
    i_next_ready = 1'b1;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", o_res_valid, 0);
    check("rst_result", o_result, 0);
    check("rst_flags", o_flags, 0);
    check("rst_pc", o_pc, 0);
    check("rst_wr_en", o_wr_en, 0);
    check("rst_illegal", o_illegal, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput();
  endtask

  logic [7:0]  opTab [14] = '{8'h01, 8'h09, 8'h21, 8'h29, 8'h31, 8'h39, 8'h89,
                              8'h40, 8'h43, 8'h47, 8'h48, 8'h4F, 8'hAF, 8'hFF};
  logic [31:0] valTab [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

  function automatic logic [31:0] pickVal();
    int k;
    k = $urandom_range(0, 7);
    return (k < 5) ? valTab[k] : $urandom;
  endfunction

  initial begin
    int cycles;
    logic [3:0] savedFlags;
    reset = 1'b0;
    i_input_valid = 0; i_pc = 0; i_opcode = 0; i_dst_val = 0; i_src_val = 0;
    i_dst_reg = 0; i_dst_is_mem = 0; i_dst_addr = 0; i_next_ready = 1;

    doReset();
    check("reset_ready", o_ready, 1);

    sendOp(8'h01, 32'hFFFF_FFFF, 32'h1);
    check("add_valid", o_res_valid, 1);
    check("add_result", o_result, 32'h0);
    check("add_flags", o_flags, 4'b0011);
    check("add_wr_en", o_wr_en, 1);

    sendOp(8'h29, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    check("sub_result", o_result, 32'h8000_0000);
    check("sub_flags", o_flags, 4'b1110);
    sendOp(8'h39, 32'h5, 32'h5);
    check("cmp_flags", o_flags, 4'b0001);
    check("cmp_wr_en", o_wr_en, 0);

    applyStimulus(1, 8'h01, 32'h1, 32'h1, 1);
    check("bp_first", o_result, 32'h2);
    repeat (3) begin
      applyStimulus(1, 8'h01, 32'h2, 32'h2, 0);
      check("bp_hold", o_result, 32'h2);
      check("bp_ready_low", o_ready, 0);
    end
    applyStimulus(1, 8'h01, 32'h2, 32'h2, 1);
    check("bp_second", o_result, 32'h4);
    applyStimulus(1, 8'h01, 32'h3, 32'h3, 1);
    check("bp_third", o_result, 32'h6);
    idleCycle();
    check("bp_drained", o_res_valid, 0);

    sendOp(8'h01, 32'hFFFF_FFFF, 32'h1);
    sendOp(8'h40, 32'hFFFF_FFFF, 32'h1234);
    check("inc_result", o_result, 32'h0);
    check("inc_flags", o_flags, 4'b0011);
    sendOp(8'hFF, 32'hDEAD_BEEF, 32'h1);
    check("ill_flag", o_illegal, 1);
    check("ill_result", o_result, 32'hDEAD_BEEF);
    check("ill_flags", o_flags, 4'b0011);
    check("ill_wr_en", o_wr_en, 0);

    if (MUL_ON) begin
      savedFlags = o_flags;
      sendOp(8'hAF, 32'hFFFF_FFFE, 32'h3);
      waitValid(cycles);
      check("imul_latency", cycles, MUL_LATENCY);
      check("imul_result", o_result, 32'hFFFF_FFFA);
      check("imul_flags", o_flags, {1'b0, savedFlags[2], 1'b0, savedFlags[0]});
      sendOp(8'hAF, 32'h0001_0000, 32'h0001_0000);
      waitValid(cycles);
      check("imul_ovf_result", o_result, 32'h0);
      check("imul_ovf_cf_of", {o_flags[3], o_flags[1]}, 2'b11);
    end

    sendOp(8'hAF, 32'h5, 32'h7);
    repeat (10) idleCycle();
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", o_res_valid, 0);
    check("async_rst_flags", o_flags, 0);
    doReset();
    applyStimulus(1, 8'h01, 32'h2, 32'h3, 1);
    check("post_rst_valid", o_res_valid, 1);
    check("post_rst_result", o_result, 32'h5);
    if (MUL_ON) begin
      repeat (40) idleCycle();
      check("no_stale_mul", o_res_valid, 0);
    end

    repeat (2000) begin
      applyStimulus($urandom_range(0, 3) != 0, opTab[$urandom_range(0, 13)],
                    pickVal(), pickVal(), $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
